// File: rtl/led_scan_pkg.sv
// Shared types and glyph decoding for the multiplexed 7-segment display path.
// Glyphs are active-high, bit0 = segment A ... bit6 = segment G.
package led_scan_pkg;

  typedef logic [6:0] seg_t;

  typedef enum logic {GAP, ON} state_e;

  localparam seg_t GLYPH_0     = 7'h3F;
  localparam seg_t GLYPH_1     = 7'h06;
  localparam seg_t GLYPH_2     = 7'h5B;
  localparam seg_t GLYPH_3     = 7'h4F;
  localparam seg_t GLYPH_4     = 7'h66;
  localparam seg_t GLYPH_5     = 7'h6D;
  localparam seg_t GLYPH_6     = 7'h7D;
  localparam seg_t GLYPH_7     = 7'h07;
  localparam seg_t GLYPH_8     = 7'h7F;
  localparam seg_t GLYPH_9     = 7'h6F;
  localparam seg_t GLYPH_A     = 7'h77;
  localparam seg_t GLYPH_B     = 7'h7C;
  localparam seg_t GLYPH_C     = 7'h39;
  localparam seg_t GLYPH_D     = 7'h5E;
  localparam seg_t GLYPH_E     = 7'h79;
  localparam seg_t GLYPH_F     = 7'h71;
  localparam seg_t GLYPH_DASH  = 7'h40;
  localparam seg_t GLYPH_BLANK = 7'h00;

  function automatic seg_t hex_glyph(input logic [3:0] nib);
    seg_t seg;
    case (nib)
      4'h0: seg = GLYPH_0;
      4'h1: seg = GLYPH_1;
      4'h2: seg = GLYPH_2;
      4'h3: seg = GLYPH_3;
      4'h4: seg = GLYPH_4;
      4'h5: seg = GLYPH_5;
      4'h6: seg = GLYPH_6;
      4'h7: seg = GLYPH_7;
      4'h8: seg = GLYPH_8;
      4'h9: seg = GLYPH_9;
      4'hA: seg = GLYPH_A;
      4'hB: seg = GLYPH_B;
      4'hC: seg = GLYPH_C;
      4'hD: seg = GLYPH_D;
      4'hE: seg = GLYPH_E;
      default: seg = GLYPH_F;
    endcase
    return seg;
  endfunction

  // ASCII: '0'-'9' keep their value in the low nibble; 'A'-'F'/'a'-'f' have
  // low nibble 1..6, so adding 9 maps them onto 10..15.
  function automatic seg_t char_to_seg(input logic [7:0] ch, input logic hex_mode);
    seg_t seg;
    seg = GLYPH_BLANK;
    if (hex_mode) begin
      seg = hex_glyph(ch[3:0]);
    end else if (ch >= 8'h30 && ch <= 8'h39) begin
      seg = hex_glyph(ch[3:0]);
    end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
      seg = hex_glyph(ch[3:0] + 4'd9);
    end else if (ch == 8'h2D) begin
      seg = GLYPH_DASH;
    end
    return seg;
  endfunction

endpackage

// File: rtl/led_scan_ctrl_if.sv
// Register-block-to-display bus for led_scan_ctrl.
// Optional blink_i exists only when LED_SCAN_BLINK_EN is defined.
interface led_scan_ctrl_if #(
  parameter int N_DIGITS = 4,
  parameter int BRIGHT_W = 4
);
  import led_scan_pkg::*;

  logic [8*N_DIGITS-1:0] digits_i;
  logic [N_DIGITS-1:0]   dp_i;
  logic                  mode_i;
  logic [BRIGHT_W-1:0]   brightness_i;
  logic                  blank_i;
`ifdef LED_SCAN_BLINK_EN
  logic [N_DIGITS-1:0]   blink_i;
`endif
  seg_t                  seg_o;
  logic                  dp_o;
  logic [N_DIGITS-1:0]   digit_en_o;
  logic                  frame_o;

  modport master (
    output digits_i, dp_i, mode_i, brightness_i, blank_i,
`ifdef LED_SCAN_BLINK_EN
    output blink_i,
`endif
    input  seg_o, dp_o, digit_en_o, frame_o
  );

  modport slave (
    input  digits_i, dp_i, mode_i, brightness_i, blank_i,
`ifdef LED_SCAN_BLINK_EN
    input  blink_i,
`endif
    output seg_o, dp_o, digit_en_o, frame_o
  );

endinterface

// File: rtl/led_seg_decode.sv
// Combinational character-to-segment decoder (active-high glyph out).
module led_seg_decode
  import led_scan_pkg::*;
(
  input  logic [7:0] char_i,
  input  logic       mode_i,
  output seg_t       seg_o
);

  assign seg_o = char_to_seg(char_i, mode_i);

endmodule

// File: rtl/led_scan_ctrl.sv
// Multiplexed 7-segment scanner: per-slot blank gap, PWM brightness,
// frame-consistent input snapshot, registered polarity-adjusted outputs.
// Optional blinking is enabled by defining LED_SCAN_BLINK_EN.
module led_scan_ctrl
  import led_scan_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 5000,
  parameter int GAP_CYCLES  = 8,
  parameter int BRIGHT_W    = 4,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit EN_ACT_LOW  = 1'b0
`ifdef LED_SCAN_BLINK_EN
  , parameter int BLINK_FRAMES = 64
`endif
) (
  input logic              clk,
  input logic              rst_n,
  led_scan_ctrl_if.slave   bus
);

  localparam int CTR_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SLOT_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CTR_W-1:0]  CTR_LAST  = CTR_W'(REFRESH_DIV - 1);
  localparam logic [CTR_W-1:0]  GAP_LAST  = CTR_W'(GAP_CYCLES - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(N_DIGITS - 1);

  if (N_DIGITS < 1 || N_DIGITS > 16 || GAP_CYCLES < 1 ||
      REFRESH_DIV <= GAP_CYCLES || REFRESH_DIV < (1 << BRIGHT_W)) begin : g_param_check
    $error("led_scan_ctrl: illegal N_DIGITS/REFRESH_DIV/GAP_CYCLES/BRIGHT_W combination");
  end

  state_e                state_q, state_d;
  logic [CTR_W-1:0]      ctr_q, ctr_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic                  first_q;

  logic [8*N_DIGITS-1:0] shadow_digits_q;
  logic [N_DIGITS-1:0]   shadow_dp_q;
  logic                  shadow_mode_q;

  seg_t                  seg_q;
  logic                  dp_q;
  logic [N_DIGITS-1:0]   en_q;
  logic                  frame_q;

  logic                  ctr_term, frame_wrap, snap, pwm_on, lit, blink_ok;
  logic [N_DIGITS-1:0]   en_act;
  logic [7:0]            cur_char;
  seg_t                  seg_dec;

  // Slot counter, sub-slot counter and scan FSM state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register sees pre-edge values.
    if (!rst_n) begin
      ctr_q   <= '0;
      slot_q  <= '0;
      state_q <= GAP;
      first_q <= 1'b1;
    end else begin
      ctr_q   <= ctr_d;
      slot_q  <= slot_d;
      state_q <= state_d;
      first_q <= 1'b0;
    end
  end

  // Next-state for counters and FSM, plus the active-high lit decision.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    ctr_d      = ctr_q + 1'b1;
    slot_d     = slot_q;
    state_d    = state_q;
    ctr_term   = (ctr_q == CTR_LAST);
    frame_wrap = ctr_term && (slot_q == SLOT_LAST);
    if (ctr_term) begin
      ctr_d  = '0;
      slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
    end
    case (state_q)
      GAP: if (ctr_q == GAP_LAST) state_d = ON;
      ON:  if (ctr_term)          state_d = GAP;
    endcase
    snap   = first_q || frame_wrap;
    pwm_on = (&bus.brightness_i) || (bus.brightness_i > ctr_q[BRIGHT_W-1:0]);
    lit    = (state_q == ON) && pwm_on && !bus.blank_i && blink_ok;
    en_act = lit ? (N_DIGITS'(1) << slot_q) : '0;
  end

`ifdef LED_SCAN_BLINK_EN
  localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [BF_W-1:0]     blink_cnt_q;
  logic                blink_off_q;
  logic [N_DIGITS-1:0] shadow_blink_q;

  // Frame counter toggling the blink phase; phase 1 forces blinking digits off.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt_q    <= '0;
      blink_off_q    <= 1'b0;
      shadow_blink_q <= '0;
    end else begin
      if (snap) shadow_blink_q <= bus.blink_i;
      if (frame_wrap) begin
        if (blink_cnt_q == BF_W'(BLINK_FRAMES - 1)) begin
          blink_cnt_q <= '0;
          blink_off_q <= ~blink_off_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + 1'b1;
        end
      end
    end
  end

  assign blink_ok = !(blink_off_q && shadow_blink_q[slot_q]);
`else
  assign blink_ok = 1'b1;
`endif

  // Frame snapshot of the character, decimal-point and mode inputs.
  always_ff @(posedge clk) begin
    // NOTE: the shadow copy is reset to spaces because it drives the pins
    // straight after reset; a pure data store would not need a reset.
    if (!rst_n) begin
      shadow_digits_q <= {N_DIGITS{8'h20}};
      shadow_dp_q     <= '0;
      shadow_mode_q   <= 1'b0;
    end else if (snap) begin
      shadow_digits_q <= bus.digits_i;
      shadow_dp_q     <= bus.dp_i;
      shadow_mode_q   <= bus.mode_i;
    end
  end

  assign cur_char = shadow_digits_q[8*slot_q +: 8];

  led_seg_decode u_decode (
    .char_i (cur_char),
    .mode_i (shadow_mode_q),
    .seg_o  (seg_dec)
  );

  // Output registers; pin polarity is applied here and nowhere else.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q   <= {7{SEG_ACT_LOW}};
      dp_q    <= SEG_ACT_LOW;
      en_q    <= {N_DIGITS{EN_ACT_LOW}};
      frame_q <= 1'b0;
    end else begin
      seg_q   <= seg_dec ^ {7{SEG_ACT_LOW}};
      dp_q    <= shadow_dp_q[slot_q] ^ SEG_ACT_LOW;
      en_q    <= en_act ^ {N_DIGITS{EN_ACT_LOW}};
      frame_q <= snap;
    end
  end

  assign bus.seg_o      = seg_q;
  assign bus.dp_o       = dp_q;
  assign bus.digit_en_o = en_q;
  assign bus.frame_o    = frame_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl: N_DIGITS=4, REFRESH_DIV=16, GAP_CYCLES=2,
// BRIGHT_W=2, active-low segments, active-high enables. Frame = 64 cycles.
// Within a frame, k counts negedges from the frame_o cycle (k=0); the enable
// seen at k reflects slot/ctr at k-1, so digit s is lit for k in 16s+3..16s+16.
module tb_led_scan_ctrl;

  localparam int N  = 4;
  localparam int RD = 16;
  localparam int GP = 2;
  localparam int BW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  led_scan_ctrl_if #(.N_DIGITS(N), .BRIGHT_W(BW)) bus ();

  led_scan_ctrl #(
    .N_DIGITS    (N),
    .REFRESH_DIV (RD),
    .GAP_CYCLES  (GP),
    .BRIGHT_W    (BW),
    .SEG_ACT_LOW (1'b1),
    .EN_ACT_LOW  (1'b0)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int lit_cnt [N];
  int idle_cnt;
  int odd_cnt;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance to the next negedge where frame_o is high (bounded).
  task automatic wait_frame(input string tag);
    int n;
    n = 0;
    while (bus.frame_o !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    check(tag, 32'(bus.frame_o), 32'd1);
  endtask

  // From k=0, step through k=1..64 tallying the enable patterns seen.
  task automatic tally_frame();
    for (int d = 0; d < N; d++) lit_cnt[d] = 0;
    idle_cnt = 0;
    odd_cnt  = 0;
    for (int k = 1; k <= 64; k++) begin
      tick(1);
      case (bus.digit_en_o)
        4'b0000: idle_cnt++;
        4'b0001: lit_cnt[0]++;
        4'b0010: lit_cnt[1]++;
        4'b0100: lit_cnt[2]++;
        4'b1000: lit_cnt[3]++;
        default: odd_cnt++;
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.digits_i     = "4321";
    bus.dp_i         = 4'b0000;
    bus.mode_i       = 1'b0;
    bus.brightness_i = 2'd3;
    bus.blank_i      = 1'b0;
`ifdef LED_SCAN_BLINK_EN
    bus.blink_i      = 4'b0000;
`endif

    // 1. Reset state, then first snapshot and first ON window.
    tick(3);
    check("rst_en",    32'(bus.digit_en_o), 32'h0);
    check("rst_seg",   32'(bus.seg_o),      32'h7F);
    check("rst_dp",    32'(bus.dp_o),       32'h1);
    check("rst_frame", 32'(bus.frame_o),    32'h0);
    rst_n = 1'b1;
    tick(1);
    check("boot_frame", 32'(bus.frame_o), 32'h1);
    tick(1);
    check("boot_frame_end", 32'(bus.frame_o),    32'h0);
    check("boot_gap_en",    32'(bus.digit_en_o), 32'h0);
    check("boot_seg",       32'(bus.seg_o),      32'h79);
    tick(1);
    check("boot_on_en",     32'(bus.digit_en_o), 32'h1);

    // 2. Full-brightness scan: 14 lit cycles per digit, one-hot order.
    tick(1);
    wait_frame("t2_sync");
    tally_frame();
    for (int d = 0; d < N; d++) check($sformatf("t2_lit%0d", d), 32'(lit_cnt[d]), 32'd14);
    check("t2_idle",   32'(idle_cnt),       32'd8);
    check("t2_odd",    32'(odd_cnt),        32'd0);
    check("t2_period", 32'(bus.frame_o),    32'h1);
    tick(1);
    check("t2_seg_d0", 32'(bus.seg_o),      32'h79);
    check("t2_gap_d0", 32'(bus.digit_en_o), 32'h0);
    check("t2_pulse",  32'(bus.frame_o),    32'h0);
    tick(2);
    check("t2_on_d0",  32'(bus.digit_en_o), 32'h1);
    tick(14);
    check("t2_gap_d1", 32'(bus.digit_en_o), 32'h0);
    check("t2_seg_d1", 32'(bus.seg_o),      32'h24);
    tick(2);
    check("t2_on_d1",  32'(bus.digit_en_o), 32'h2);
    tick(30);
    check("t2_seg_d3", 32'(bus.seg_o),      32'h19);
    tick(15);
    check("t2_period2", 32'(bus.frame_o),   32'h1);

    // 3. Mid-frame input change stays hidden until the next snapshot.
    tick(33);
    bus.digits_i = "8888";
    tick(7);
    check("t3_seg_d2", 32'(bus.seg_o),      32'h30);
    check("t3_en_d2",  32'(bus.digit_en_o), 32'h4);
    tick(16);
    check("t3_seg_d3", 32'(bus.seg_o),      32'h19);
    check("t3_en_d3",  32'(bus.digit_en_o), 32'h8);
    tick(8);
    check("t3_frame",  32'(bus.frame_o),    32'h1);
    check("t3_old_d3", 32'(bus.seg_o),      32'h19);
    tick(1);
    check("t3_new_d0", 32'(bus.seg_o),      32'h00);

    // 4. PWM: brightness 1 lights only ctr[1:0]==0 inside ON; 0 is fully off.
    bus.brightness_i = 2'd1;
    tick(1);
    wait_frame("t4_sync");
    tally_frame();
    for (int d = 0; d < N; d++) check($sformatf("t4_lit%0d", d), 32'(lit_cnt[d]), 32'd3);
    check("t4_odd", 32'(odd_cnt), 32'd0);
    tick(4);
    check("t4_k4", 32'(bus.digit_en_o), 32'h0);
    tick(1);
    check("t4_k5", 32'(bus.digit_en_o), 32'h1);
    tick(1);
    check("t4_k6", 32'(bus.digit_en_o), 32'h0);
    bus.brightness_i = 2'd0;
    tick(1);
    wait_frame("t4_sync0");
    tally_frame();
    check("t4_off_idle", 32'(idle_cnt), 32'd64);

    // 5. Decode modes and decimal point.
    bus.brightness_i = 2'd3;
    bus.mode_i       = 1'b1;
    bus.digits_i     = {8'h00, 8'h00, 8'h0B, 8'hFA};
    bus.dp_i         = 4'b0001;
    tick(1);
    wait_frame("t5_sync_hex");
    tick(1);
    check("t5_hex_a",  32'(bus.seg_o), 32'h08);
    check("t5_dp_on",  32'(bus.dp_o),  32'h0);
    tick(16);
    check("t5_hex_b",  32'(bus.seg_o), 32'h03);
    check("t5_dp_off", 32'(bus.dp_o),  32'h1);
    bus.mode_i   = 1'b0;
    bus.digits_i = {8'h30, 8'h46, 8'h2D, 8'h7A};
    bus.dp_i     = 4'b0000;
    tick(1);
    wait_frame("t5_sync_ascii");
    tick(1);
    check("t5_ascii_z",    32'(bus.seg_o), 32'h7F);
    tick(16);
    check("t5_ascii_dash", 32'(bus.seg_o), 32'h3F);
    tick(16);
    check("t5_ascii_F",    32'(bus.seg_o), 32'h0E);
    tick(16);
    check("t5_ascii_0",    32'(bus.seg_o), 32'h40);

    // 6. blank_i mid-slot, then reset in slot 3.
    bus.digits_i = "4321";
    tick(1);
    wait_frame("t6_sync");
    tick(8);
    check("t6_pre_blank", 32'(bus.digit_en_o), 32'h1);
    bus.blank_i = 1'b1;
    tick(1);
    check("t6_blank1", 32'(bus.digit_en_o), 32'h0);
    tick(1);
    check("t6_blank2", 32'(bus.digit_en_o), 32'h0);
    bus.blank_i = 1'b0;
    tick(1);
    check("t6_resume", 32'(bus.digit_en_o), 32'h1);
    tick(8);
    check("t6_slot1",  32'(bus.digit_en_o), 32'h2);
    tick(33);
    check("t6_slot3",  32'(bus.digit_en_o), 32'h8);
    rst_n = 1'b0;
    tick(1);
    check("t6_rst_en",    32'(bus.digit_en_o), 32'h0);
    check("t6_rst_seg",   32'(bus.seg_o),      32'h7F);
    check("t6_rst_dp",    32'(bus.dp_o),       32'h1);
    check("t6_rst_frame", 32'(bus.frame_o),    32'h0);
    rst_n = 1'b1;
    tick(1);
    check("t6_boot_frame", 32'(bus.frame_o), 32'h1);
    tick(1);
    check("t6_boot_seg",   32'(bus.seg_o),      32'h79);
    check("t6_boot_gap",   32'(bus.digit_en_o), 32'h0);
    tick(1);
    check("t6_boot_d0",    32'(bus.digit_en_o), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_scan_ctrl.md
Name: led_scan_ctrl

Overview:
- Parametrised multiplexed 7-segment display driver. Scans N_DIGITS common-enable digits from a packed character bus.
- Generalises the fixed 4-digit ASCII scanner with:
  - a frame-consistent input snapshot,
  - an anti-ghosting blank gap,
  - PWM brightness,
  - hex/ASCII decode modes,
  - a per-digit decimal point,
  - configurable polarity.
- Sits between the peripheral register block and the board LED pins.

Parameters:
- N_DIGITS, 4, number of multiplexed digits (1..16).
- REFRESH_DIV, 5000, Clk cycles per digit slot. Must be > GAP_CYCLES and >= 2**BRIGHT_W; checked by an elaboration assertion.
- GAP_CYCLES, 8, blank cycles at the start of each slot, all enables inactive.
- BRIGHT_W, 4, brightness field width.
- SEG_ACT_LOW, 1, 1 = segment/dp outputs driven low when lit.
- EN_ACT_LOW, 0, 1 = digit enables active-low.

Ports:
- Clk  in  1  system clock.
- Rst_n  in  1  synchronous active-low reset.
- digits_i  in  8*N_DIGITS  character per digit; digit k at [8k+7:8k].
- dp_i  in  N_DIGITS  decimal point request per digit.
- mode_i  in  1  0 = ASCII decode, 1 = hex decode of low nibble.
- brightness_i  in  BRIGHT_W  duty level; 0 = off, all-ones = fully on.
- blank_i  in  1  force all digits off; scanning continues.
- seg_o  out  7  segments, bit0 = A … bit6 = G.
- dp_o  out  1  decimal point segment.
- digit_en_o  out  N_DIGITS  one-hot digit enable; bit k selects digit k.
- frame_o  out  1  one-cycle pulse when slot index wraps to 0.

Behaviour:
- Reset (synchronous, Rst_n low on a rising Clk edge):
  - slot = 0, ctr = 0, FSM = GAP.
  - digit_en_o all inactive; seg_o and dp_o inactive (7'h7F / 1 with SEG_ACT_LOW = 1); frame_o = 0.
  - Shadow registers are loaded with space characters (blank glyph) and dp = 0.
- Counters:
  - ctr counts 0..REFRESH_DIV-1.
  - At terminal count, ctr returns to 0 and slot increments; slot wraps from N_DIGITS-1 to 0.
- Frame snapshot:
  - When slot wraps to 0 (and on the first cycle after reset release), digits_i, dp_i and mode_i are copied into shadow registers.
  - All displayed data comes from the shadow registers, so input changes mid-frame never appear until the next frame.
  - frame_o pulses on the same cycle the snapshot is taken.
- FSM, two states:
  - GAP: enables inactive. Moves to ON when ctr == GAP_CYCLES-1.
  - ON: moves to GAP at ctr terminal count.
- PWM:
  - In ON, the digit is lit when brightness_i == all-ones, or brightness_i > ctr[BRIGHT_W-1:0].
  - brightness_i is sampled live; a change takes effect on the next cycle.
- Lit condition: ON AND PWM-active AND !blank_i. digit_en_o = one-hot(slot) when lit, all inactive otherwise.
- Registered outputs:
  - seg_o, dp_o, digit_en_o and frame_o are all registered: 1 cycle after internal state.
  - seg_o/dp_o always show the current slot's glyph regardless of the enable.
- Decode:
  - ASCII mode:
    - '0'-'9' → digit glyphs.
    - 'A'-'F' and 'a'-'f' → hex glyphs.
    - '-' → G only.
    - Any other code → blank.
  - Hex mode: low nibble 0-F → hex glyph; high nibble ignored.
- Polarity: applied at the output registers only. Internal logic is active-high.
- blank_i: deasserting it mid-slot resumes lighting on the next cycle; slot timing is unaffected.
- Reset mid-frame: immediate return to the reset state; no partial slot completes.

Optional Feature:
- Macro: LED_SCAN_BLINK_EN.
- Defined:
  - Adds port blink_i [N_DIGITS-1:0] and parameter BLINK_FRAMES (default 64).
  - A frame counter toggles a blink phase every BLINK_FRAMES frames.
  - Digits whose blink bit is set are forced off during the off-phase.
  - blink_i is captured in the frame snapshot.
  - Blink phase resets to on-phase.
- Undefined: no blink_i port, no frame counter; behaviour as above.

Decomposition:
- Package led_scan_pkg holds:
  - typedef seg_t (logic [6:0]);
  - state enum {GAP, ON};
  - glyph constants for 0-F, dash and blank (active-high);
  - char_to_seg function.
- One sub-module, led_seg_decode: combinational (char, mode) → seg_t. Reused by the future register-mapped display block.

Test Plan (N_DIGITS=4, REFRESH_DIV=16, GAP_CYCLES=2, BRIGHT_W=2, SEG_ACT_LOW=1, EN_ACT_LOW=0):
1. Rst_n low 3 cycles → digit_en_o = 4'b0000, seg_o = 7'h7F, frame_o = 0. After release: first frame_o pulse, then digit_en_o = 4'b0001 from the ON window (ctr = 2, output 1 cycle later).
2. digits_i = "4321" (digit0 = '1'), brightness 3 → enables step 0001, 0010, 0100, 1000, each lit 14 of 16 cycles. During digit0, seg_o = 7'h79.
3. Change digits_i from "4321" to "8888" at slot 2 → slots 2-3 still show '3','4'; '8' (7'h00) appears only after the next frame_o.
4. brightness_i = 1 → digit lit only when ctr[1:0] == 0 within ON. brightness_i = 0 → digit_en_o stays 0000 for a full frame.
5. mode_i = 1, digit0 = 8'hFA → seg_o = 7'h08 ('A'). mode_i = 0, digit0 = 8'h7A ('z') → seg_o = 7'h7F.
6. Mid-slot: blank_i high → 0000 on the next cycle with slot timing unchanged. Rst_n low at slot 3 → immediate reset state; scanning restarts at digit0.
